// File: rtl/sha256_round_stage_59_pkg.sv
// Shared SHA-256 round definitions: widths, the K constant table, state layout,
// buffer states and the round boolean functions used by every round stage.
package sha256_round_stage_59_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned STATE_W = 256;
  localparam int unsigned WIN_W   = 352;

  typedef logic [WORD_W-1:0] word_t;

  // Working variables in transport order: a occupies the top word.
  typedef struct packed {
    word_t a;
    word_t b;
    word_t c;
    word_t d;
    word_t e;
    word_t f;
    word_t g;
    word_t h;
  } sha_state_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  localparam word_t K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t ch(input word_t e, input word_t f, input word_t g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_core.sv
// Combinational SHA-256 compression round: one state update from W_t and K_t.
module sha256_round_core
  import sha256_round_stage_59_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [WORD_W-1:0]  w,
  input  logic [WORD_W-1:0]  k,
  output logic [STATE_W-1:0] next_state
);

  sha_state_t s;
  sha_state_t n;
  word_t      t1;
  word_t      t2;

  assign s  = state;
  assign t1 = s.h + big_sigma1(s.e) + ch(s.e, s.f, s.g) + k + w;
  assign t2 = big_sigma0(s.a) + maj(s.a, s.b, s.c);

  always_comb begin
    n.a = t1 + t2;
    n.b = s.a;
    n.c = s.b;
    n.d = s.c;
    n.e = s.d + t1;
    n.f = s.e;
    n.g = s.f;
    n.h = s.g;
  end

  assign next_state = n;

endmodule

// File: rtl/sha256_round_stage_59.sv
// SHA-256 round 59 pipeline stage: round core feeding a 2-entry output/skid buffer
// whose in_ready depends only on the registered skid occupancy.
module sha256_round_stage_59
  import sha256_round_stage_59_pkg::*;
#(
  parameter logic [WORD_W-1:0] ROUND_K = K_TABLE[59]
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  input  logic [WIN_W-1:0]   w_block_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out,
  output logic [WIN_W-1:0]   w_block_out
);

  buf_state_e         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic               skid_full_q, skid_full_d;
  logic [STATE_W-1:0] out_state_q, out_state_d;
  logic [WIN_W-1:0]   out_w_q, out_w_d;
  logic [STATE_W-1:0] skid_state_q, skid_state_d;
  logic [WIN_W-1:0]   skid_w_q, skid_w_d;
  logic [STATE_W-1:0] round_state;
  logic               in_xfer;
  logic               out_xfer;

  sha256_round_core u_core (
    .state      (state_in),
    .w          (w_block_in[WORD_W-1:0]),
    .k          (ROUND_K),
    .next_state (round_state)
  );

  assign in_xfer  = in_valid & ~skid_full_q;
  assign out_xfer = out_valid_q & out_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= BUF_EMPTY;
      out_valid_q  <= 1'b0;
      skid_full_q  <= 1'b0;
      out_state_q  <= '0;
      out_w_q      <= '0;
      skid_state_q <= '0;
      skid_w_q     <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      skid_full_q  <= skid_full_d;
      out_state_q  <= out_state_d;
      out_w_q      <= out_w_d;
      skid_state_q <= skid_state_d;
      skid_w_q     <= skid_w_d;
    end
  end

  // Buffer sequencing; data registers move only on a transfer.
  always_comb begin
    state_d      = state_q;
    out_state_d  = out_state_q;
    out_w_d      = out_w_q;
    skid_state_d = skid_state_q;
    skid_w_d     = skid_w_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_xfer) begin
          out_state_d = round_state;
          out_w_d     = w_block_in;
          state_d     = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (in_xfer && out_xfer) begin
          out_state_d = round_state;
          out_w_d     = w_block_in;
        end else if (in_xfer) begin
          skid_state_d = round_state;
          skid_w_d     = w_block_in;
          state_d      = BUF_FULL;
        end else if (out_xfer) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (out_xfer) begin
          out_state_d = skid_state_q;
          out_w_d     = skid_w_q;
          state_d     = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    out_valid_d = (state_d != BUF_EMPTY);
    skid_full_d = (state_d == BUF_FULL);
  end

  assign in_ready    = ~skid_full_q;
  assign out_valid   = out_valid_q;
  assign state_out   = out_state_q;
  assign w_block_out = out_w_q;

endmodule

// File: tb/tb_sha256_round_stage_59.sv
// Randomized and directed bench for the round-59 stage against a queue-based reference.
module tb_sha256_round_stage_59;

  logic         CLK = 1'b0;
  logic         RST;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] state_in;
  logic [351:0] w_block_in;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] state_out;
  logic [351:0] w_block_out;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  typedef struct packed {
    logic [255:0] s;
    logic [351:0] w;
  } beat_t;

  beat_t exp_q[$];

  sha256_round_stage_59 dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .state_in    (state_in),
    .w_block_in  (w_block_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .state_out   (state_out),
    .w_block_out (w_block_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [351:0] got, input logic [351:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] dbl;
    dbl = {x, x} >> n;
    return dbl[31:0];
  endfunction

  // Reference round, written straight from the SHA-256 round equations.
  function automatic logic [255:0] ref_round(input logic [255:0] s, input logic [31:0] wt);
    logic [31:0] v [8];
    logic [63:0] t1, t2;
    logic [31:0] s1, s0, chv, mj;
    for (int i = 0; i < 8; i++) v[i] = s[255 - 32*i -: 32];
    s1  = ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25);
    s0  = ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22);
    chv = (v[4] & v[5]) | (~v[4] & v[6]);
    mj  = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    t1  = (64'(v[7]) + 64'(s1) + 64'(chv) + 64'h8cc70208 + 64'(wt)) % 64'h1_0000_0000;
    t2  = (64'(s0) + 64'(mj)) % 64'h1_0000_0000;
    return {32'((t1 + t2) % 64'h1_0000_0000), v[0], v[1], v[2],
            32'((64'(v[3]) + t1) % 64'h1_0000_0000), v[4], v[5], v[6]};
  endfunction

  function automatic logic [255:0] rnd_state();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [351:0] rnd_win();
    logic [351:0] r;
    for (int i = 0; i < 11; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Called at a falling edge: check outputs, drive one cycle, advance the model.
  task automatic step(input logic v, input logic [255:0] s, input logic [351:0] w, input logic rdy);
    bit    acc, emit;
    beat_t b;
    check("out_valid", 352'(out_valid), 352'(exp_q.size() > 0));
    check("in_ready", 352'(in_ready), 352'(exp_q.size() < 2));
    if (exp_q.size() > 0) begin
      check("state_out", 352'(state_out), 352'(exp_q[0].s));
      check("w_block_out", w_block_out, exp_q[0].w);
    end
    in_valid   = v;
    state_in   = s;
    w_block_in = w;
    out_ready  = rdy;
    acc  = v && (exp_q.size() < 2);
    emit = rdy && (exp_q.size() > 0);
    if (emit) void'(exp_q.pop_front());
    if (acc) begin
      b.s = ref_round(s, w[31:0]);
      b.w = w;
      exp_q.push_back(b);
    end
    @(negedge CLK);
  endtask

  logic [255:0] bs [3];
  logic [351:0] bw [3];

  initial begin
    RST        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    state_in   = '0;
    w_block_in = '0;
    repeat (2) @(negedge CLK);
    check("rst_out_valid", 352'(out_valid), 352'(0));
    check("rst_in_ready", 352'(in_ready), 352'(1));
    check("rst_state_out", 352'(state_out), 352'(0));
    check("rst_w_block_out", w_block_out, 352'(0));
    RST = 1'b0;

    // Zero round, accepted on the first edge after reset release.
    step(1'b1, '0, '0, 1'b1);
    check("zero_round", 352'(state_out), 352'({32'h8cc70208, 96'h0, 32'h8cc70208, 96'h0}));
    step(1'b1, '0, 352'h1, 1'b1);
    check("w_dep_state", 352'(state_out), 352'({32'h8cc70209, 96'h0, 32'h8cc70209, 96'h0}));
    check("w_dep_window", w_block_out, 352'h1);
    step(1'b1, {96'h0, 32'h12345678, 96'h0, 32'h7338fdf7}, 352'h1, 1'b1);
    check("wrap_state", 352'(state_out), 352'({128'h0, 32'h12345678, 96'h0}));
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);

    // Backpressure: three offers, two accepted, then ordered drain.
    for (int i = 0; i < 3; i++) begin
      bs[i] = rnd_state();
      bw[i] = rnd_win();
    end
    step(1'b1, bs[0], bw[0], 1'b0);
    step(1'b1, bs[1], bw[1], 1'b0);
    check("bp_in_ready_low", 352'(in_ready), 352'(0));
    check("bp_hold_first", 352'(state_out), 352'(ref_round(bs[0], bw[0][31:0])));
    step(1'b1, bs[2], bw[2], 1'b0);
    check("bp_still_first", w_block_out, bw[0]);
    step(1'b0, '0, '0, 1'b1);
    check("bp_drain_second", 352'(state_out), 352'(ref_round(bs[1], bw[1][31:0])));
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);

    // Simultaneous transfers holding the buffer at one entry.
    step(1'b1, rnd_state(), rnd_win(), 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rnd_state(), rnd_win(), 1'b1);
      check("simul_in_ready", 352'(in_ready), 352'(1));
    end
    step(1'b0, '0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rnd_state(), rnd_win(), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);

    // Asynchronous reset while the buffer is full.
    step(1'b1, rnd_state(), rnd_win(), 1'b0);
    step(1'b1, rnd_state(), rnd_win(), 1'b0);
    step(1'b0, '0, '0, 1'b0);
    #2 RST = 1'b1;
    #1;
    check("async_rst_out_valid", 352'(out_valid), 352'(0));
    check("async_rst_in_ready", 352'(in_ready), 352'(1));
    exp_q.delete();
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b1);
    step(1'b1, rnd_state(), rnd_win(), 1'b1);
    step(1'b0, '0, '0, 1'b1);
    step(1'b0, '0, '0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_round_stage_59.md
SHA256_ROUND_STAGE_59 -- requirements
Module: sha256_round_stage_59

Interface
REQ-001 Parameter ROUND_K, default 32'h8cc70208, SHALL be the SHA-256 round constant K[59] applied by this stage.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  input  1  SHALL indicate that state_in and w_block_in carry a valid beat.
REQ-005 in_ready  output  1  SHALL indicate that the stage accepts a beat this cycle.
REQ-006 state_in  input  256  SHALL carry working variables {a,b,c,d,e,f,g,h}, with a in [255:224].
REQ-007 w_block_in  input  352  SHALL carry the 11-word schedule window from the upstream W-memory stage, with W_t in [31:0].
REQ-008 out_valid  output  1  SHALL indicate that state_out and w_block_out carry a valid beat.
REQ-009 out_ready  input  1  SHALL indicate that the downstream stage accepts a beat this cycle.
REQ-010 state_out  output  256  SHALL carry the post-round {a',b',c',d',e',f',g',h'}.
REQ-011 w_block_out  output  352  SHALL carry w_block_in unchanged, aligned with its state_out beat.

Function
REQ-012 A transfer SHALL occur on a rising edge when the valid and ready of the same port are both high.
REQ-013 The stage SHALL compute one SHA-256 round per beat:
- T1 = h + Sigma1(e) + Ch(e,f,g) + ROUND_K + W_t
- T2 = Sigma0(a) + Maj(a,b,c)
- all additions modulo 2^32, carries discarded
REQ-014 The function definitions SHALL be:
- Sigma1 = ROTR6^ROTR11^ROTR25 of e
- Sigma0 = ROTR2^ROTR13^ROTR22 of a
- Ch = (e&f)^(~e&g)
- Maj = (a&b)^(a&c)^(b&c)
REQ-015 The output word assignment SHALL be a'=T1+T2, b'=a, c'=b, d'=c, e'=d+T1, f'=e, g'=f, h'=g.
REQ-016 The round result SHALL be computed combinationally from the inputs and captured in an output register.
REQ-017 The stage SHALL contain an output register plus one skid register, a 2-entry buffer in total.
REQ-018 Latency SHALL be exactly 1 cycle from an input transfer to out_valid, when the buffer is empty.
REQ-019 in_ready SHALL be driven from the registered skid_full flag only, with no combinational path from out_ready.
REQ-020 The buffer state machine SHALL have three states:
- EMPTY: out_valid=0, in_ready=1.
- ONE: out_valid=1, in_ready=1.
- FULL: out_valid=1, in_ready=0.
REQ-021 The state transitions SHALL be:
- EMPTY + input transfer -> ONE.
- ONE + input transfer without output transfer -> FULL, with the new beat stored in skid.
- ONE + output transfer without input transfer -> EMPTY.
- ONE + simultaneous input and output transfers -> stay in ONE, with the output register loaded with the new beat.
- FULL + output transfer -> ONE, with the skid beat moved into the output register.
REQ-022 In FULL, in_valid SHALL be ignored, since in_ready is 0.
REQ-023 Beats SHALL leave in acceptance order, with no loss or duplication.
REQ-024 While out_valid=1 and out_ready=0, state_out and w_block_out SHALL hold stable.
REQ-025 Data registers SHALL load only on a transfer, and the outputs SHALL be don't-care when out_valid=0.

Reset
REQ-026 While RST=1, the stage SHALL force state EMPTY, out_valid=0, in_ready=1 and skid_full=0, and SHALL zero state_out and w_block_out.
REQ-027 Reset asserted mid-operation SHALL discard buffered beats immediately, without waiting for a clock edge.
REQ-028 On the first edge after RST deasserts, the stage SHALL accept a beat.

Structure
REQ-029 A shared package SHALL hold:
- the 64-entry K constant table
- the word width (32), state width (256) and window width (352) constants
REQ-030 The package SHALL hold the Sigma0, Sigma1, Ch and Maj functions, so that all round stages share one definition.
REQ-031 The round datapath SHALL be one combinational sub-module, sha256_round_core, with ports state, w, k and next_state.
REQ-032 The handshake and buffer logic SHALL be implemented in sha256_round_stage_59 itself.

Verification
REQ-033 Zero round: state_in=0, w_block_in=0, out_ready=1 -> next cycle out_valid=1, a'=e'=32'h8cc70208, all other words 0.
REQ-034 W dependency: state_in=0, W_t=32'h00000001 -> a'=e'=32'h8cc70209; w_block_out equals w_block_in.
REQ-035 Wrap-around: h=32'h7338fdf7, d=32'h12345678, other words 0, W_t=1 -> T1=0, a'=0, e'=32'h12345678, h'=0.
REQ-036 Backpressure: out_ready=0 while 3 beats are offered -> 2 beats accepted and in_ready=0 after the second; outputs hold the first beat; releasing out_ready drains beats 1 then 2 in order.
REQ-037 Simultaneous transfer: in ONE state, in_valid=1 and out_ready=1 for 10 cycles -> 10 beats out in order, state stays ONE, in_ready never drops.
REQ-038 Reset mid-operation: assert RST in FULL between clock edges -> out_valid=0 and in_ready=1 immediately, with no stale beat emitted after release.
